// File: rtl/pixel_fetch_fifo.sv
// Pixel FIFO between the tile fetcher and the LCD line writer: unpacks one tile row into 8 pixels per push and pops one pixel per cycle.
// Optional fine-scroll discard of leading pixels is enabled by defining PIXFIFO_DISCARD_EN.
module pixel_fetch_fifo #(
    parameter int PIXEL_BITS   = 2,
    parameter int SHADE_BITS   = 2,
    parameter int DEPTH        = 16,
    parameter int NUM_PALETTES = 2,
    localparam int PSW = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1,
    localparam int AW  = $clog2(DEPTH),
    localparam int LW  = AW + 1,
    localparam int NE  = 2 ** PIXEL_BITS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 push_valid,
    output logic                                 push_ready,
    input  logic [PIXEL_BITS*8-1:0]              push_planes,
    input  logic [PSW-1:0]                       push_pal,
    input  logic                                 push_xflip,
    input  logic                                 discard_load,
    input  logic [2:0]                           discard_count,
    output logic                                 pix_valid,
    input  logic                                 pix_ready,
    output logic [PIXEL_BITS-1:0]                pix_index,
    output logic [PSW-1:0]                       pix_pal,
    output logic [SHADE_BITS-1:0]                pix_shade,
    input  logic [NUM_PALETTES*NE*SHADE_BITS-1:0] palettes,
    output logic [LW-1:0]                        level
);

    logic [PIXEL_BITS-1:0] idx_mem_r [DEPTH];
    logic [PSW-1:0]        pal_mem_r [DEPTH];
    logic [AW-1:0]         rd_ptr_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [LW-1:0]         level_r;

    logic                  push_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  pix_valid_s;
    logic [PIXEL_BITS-1:0] row_idx_s [8];
    logic [PIXEL_BITS-1:0] pix_index_s;
    logic [PSW-1:0]        pix_pal_s;
    logic [SHADE_BITS-1:0] pix_shade_s;

    // A same-cycle pop is deliberately not credited so the ready path stays short.
    assign push_ready_s = !reset && !flush && (level_r <= LW'(DEPTH - 8));
    assign push_s       = push_valid && push_ready_s;
    assign pop_s        = pix_valid_s && pix_ready;

`ifdef PIXFIFO_DISCARD_EN
    logic [2:0] discard_rem_r;

    assign drop_s      = (discard_rem_r != 3'd0) && (level_r != '0);
    assign pix_valid_s = (level_r != '0) && (discard_rem_r == 3'd0);

    // Discard counter: a load wins over the countdown, and survives a flush for line-start scroll.
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_rem_r <= 3'd0;
        end else if (discard_load) begin
            discard_rem_r <= discard_count;
        end else if (drop_s && !flush) begin
            discard_rem_r <= discard_rem_r - 3'd1;
        end
    end
`else
    logic unused_discard_s;

    assign unused_discard_s = ^{discard_load, discard_count};
    assign drop_s           = 1'b0;
    assign pix_valid_s      = (level_r != '0);
`endif

    // Unpack one tile row; pixel 0 is the leftmost (MSB) unless the row is X-flipped.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            row_idx_s[k] = '0;
            for (int p = 0; p < PIXEL_BITS; p++) begin
                if (push_xflip) begin
                    row_idx_s[k][p] = push_planes[8*p + k];
                end else begin
                    row_idx_s[k][p] = push_planes[8*p + 7 - k];
                end
            end
        end
    end

    // Pixel storage; contents are only ever observed behind a non-zero level.
    always_ff @(posedge clk) begin
        if (push_s) begin
            for (int k = 0; k < 8; k++) begin
                idx_mem_r[wr_ptr_r + AW'(k)] <= row_idx_s[k];
                pal_mem_r[wr_ptr_r + AW'(k)] <= push_pal;
            end
        end
    end

    // Pointers and occupancy; flush discards any push, pop or drop of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(8);
            end
            if (pop_s || drop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_r + (push_s ? LW'(8) : LW'(0)) - ((pop_s || drop_s) ? LW'(1) : LW'(0));
        end
    end

    assign pix_index_s = idx_mem_r[rd_ptr_r];
    assign pix_pal_s   = pal_mem_r[rd_ptr_r];

    // Live palette lookup; a select beyond the bank reads as shade 0.
    always_comb begin
        pix_shade_s = '0;
        if (int'(pix_pal_s) < NUM_PALETTES) begin
            pix_shade_s = palettes[(int'(pix_pal_s) * NE + int'(pix_index_s)) * SHADE_BITS +: SHADE_BITS];
        end else begin
            pix_shade_s = '0;
        end
    end

    assign push_ready = push_ready_s;
    assign pix_valid  = pix_valid_s;
    assign pix_index  = pix_index_s;
    assign pix_pal    = pix_pal_s;
    assign pix_shade  = pix_shade_s;
    assign level      = level_r;

endmodule

// File: tb/tb_pixel_fetch_fifo.sv
// Directed bench for pixel_fetch_fifo: a table of tile rows with expected pixel indices, plus hand sequences for flow control, discard, flush, live palettes and reset.
module tb_pixel_fetch_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_planes;
    logic [0:0]  push_pal;
    logic        push_xflip;
    logic        discard_load;
    logic [2:0]  discard_count;
    logic        pix_valid;
    logic        pix_ready;
    logic [1:0]  pix_index;
    logic [0:0]  pix_pal;
    logic [1:0]  pix_shade;
    logic [15:0] palettes;
    logic [4:0]  level;

    int n_checks = 0;
    int n_errors = 0;

    pixel_fetch_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_planes   (push_planes),
        .push_pal      (push_pal),
        .push_xflip    (push_xflip),
        .discard_load  (discard_load),
        .discard_count (discard_count),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_index     (pix_index),
        .pix_pal       (pix_pal),
        .pix_shade     (pix_shade),
        .palettes      (palettes),
        .level         (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] planes;
        logic        pal;
        logic        xflip;
        logic [15:0] idx;   // pixel k expected index at [2k+1:2k]
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] shade_of(input logic pal, input logic [1:0] idx);
        int base;
        base = (int'(pal) * 4 + int'(idx)) * 2;
        return palettes[base +: 2];
    endfunction

    task automatic push_row(input string nm, input logic [15:0] planes, input logic pal, input logic xf);
        push_valid  = 1'b1;
        push_planes = planes;
        push_pal    = pal;
        push_xflip  = xf;
        #1;
        check({nm, "_push_ready"}, push_ready, 1'b1);
        step();
        push_valid = 1'b0;
    endtask

    task automatic expect_row(input string nm, input logic [15:0] exp, input logic pal, input int start);
        for (int k = start; k < 8; k++) begin
            check($sformatf("%s_valid%0d", nm, k), pix_valid, 1'b1);
            check($sformatf("%s_idx%0d", nm, k), pix_index, exp[2*k +: 2]);
            check($sformatf("%s_pal%0d", nm, k), pix_pal, pal);
            check($sformatf("%s_shade%0d", nm, k), pix_shade, shade_of(pal, exp[2*k +: 2]));
            step();
        end
    endtask

    initial begin
        vecs[0] = '{16'h7E3C, 1'b0, 1'b0, 16'h2FF8};
        vecs[1] = '{16'h7E3C, 1'b0, 1'b1, 16'h2FF8};
        vecs[2] = '{16'h0001, 1'b0, 1'b0, 16'h4000};
        vecs[3] = '{16'h0001, 1'b0, 1'b1, 16'h0001};
        vecs[4] = '{16'hF00F, 1'b1, 1'b0, 16'h55AA};
        vecs[5] = '{16'hF00F, 1'b1, 1'b1, 16'hAA55};

        reset         = 1'b1;
        flush         = 1'b0;
        push_valid    = 1'b0;
        push_planes   = 16'h0000;
        push_pal      = 1'b0;
        push_xflip    = 1'b0;
        discard_load  = 1'b0;
        discard_count = 3'd0;
        pix_ready     = 1'b0;
        palettes      = {8'hE4, 8'h1B};

        step();
        step();
        check("rst_level", level, 5'd0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_push_ready", push_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_push_ready", push_ready, 1'b1);

        // Row unpack table, streamed at full rate.
        pix_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            push_row($sformatf("row%0d", v), vecs[v].planes, vecs[v].pal, vecs[v].xflip);
            expect_row($sformatf("row%0d", v), vecs[v].idx, vecs[v].pal, 0);
            check($sformatf("row%0d_level_end", v), level, 5'd0);
        end

        // Backpressure and ready threshold.
        pix_ready = 1'b0;
        push_row("bp_a", 16'h7E3C, 1'b0, 1'b0);
        push_row("bp_b", 16'h7E3C, 1'b0, 1'b0);
        check("bp_level16", level, 5'd16);
        check("bp_ready_full", push_ready, 1'b0);
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        check("bp_level15", level, 5'd15);
        check("bp_ready_15", push_ready, 1'b0);
        pix_ready = 1'b1;
        repeat (7) step();
        check("bp_level8", level, 5'd8);
        check("bp_ready_8", push_ready, 1'b1);
        push_valid  = 1'b1;
        push_planes = 16'h7E3C;
        step();
        push_valid = 1'b0;
        check("bp_push_pop_level", level, 5'd15);
        for (int i = 0; i < 40 && level != 5'd0; i++) step();
        check("bp_drain_level", level, 5'd0);

        // Fine-scroll discard of 3 leading pixels.
        discard_load  = 1'b1;
        discard_count = 3'd3;
        push_row("disc", 16'h00FF, 1'b0, 1'b0);
        discard_load = 1'b0;
`ifdef PIXFIFO_DISCARD_EN
        for (int i = 0; i < 3; i++) begin
            check($sformatf("disc_hidden%0d", i), pix_valid, 1'b0);
            step();
        end
        expect_row("disc", 16'h5555, 1'b0, 3);
`else
        expect_row("disc", 16'h5555, 1'b0, 0);
`endif
        check("disc_level_end", level, 5'd0);

        // Flush at level 10 together with a discard load.
        pix_ready = 1'b0;
        push_row("fl_a", 16'h7E3C, 1'b0, 1'b0);
        push_row("fl_b", 16'h7E3C, 1'b0, 1'b0);
        pix_ready = 1'b1;
        repeat (6) step();
        pix_ready = 1'b0;
        check("fl_level10", level, 5'd10);
        flush         = 1'b1;
        discard_load  = 1'b1;
        discard_count = 3'd2;
        #1;
        check("fl_ready_during", push_ready, 1'b0);
        step();
        flush        = 1'b0;
        discard_load = 1'b0;
        check("fl_level0", level, 5'd0);
        check("fl_pix_valid", pix_valid, 1'b0);
        pix_ready = 1'b1;
        push_row("fl_c", 16'h7E3C, 1'b0, 1'b0);
`ifdef PIXFIFO_DISCARD_EN
        for (int i = 0; i < 2; i++) begin
            check($sformatf("fl_hidden%0d", i), pix_valid, 1'b0);
            step();
        end
        expect_row("fl_c", 16'h2FF8, 1'b0, 2);
`else
        expect_row("fl_c", 16'h2FF8, 1'b0, 0);
`endif
        check("fl_level_end", level, 5'd0);

        // Live palette write while a palette-1 pixel is held, then reset mid-stream.
        pix_ready = 1'b0;
        push_row("pal", 16'hF00F, 1'b1, 1'b0);
        check("pal_valid", pix_valid, 1'b1);
        check("pal_sel", pix_pal, 1'b1);
        check("pal_idx", pix_index, 2'd2);
        check("pal_shade_before", pix_shade, 2'd2);
        palettes[15:8] = 8'h1B;
        #1;
        check("pal_shade_after", pix_shade, 2'd1);
        check("pal_shade_model", pix_shade, shade_of(1'b1, 2'd2));
        reset = 1'b1;
        #1;
        check("mid_rst_push_ready", push_ready, 1'b0);
        step();
        check("mid_rst_pix_valid", pix_valid, 1'b0);
        check("mid_rst_level", level, 5'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_release_ready", push_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
